axis_fc_layer_engine: RTL and testbench
=======================================

Name: axis_fc_layer_engine

Overview:
Parametrised AXI-Stream fully-connected layer coprocessor. It is the single-layer building block for the MNIST accelerator datapath. After reset it accepts one load frame of weights and biases, then repeatedly accepts input vectors. For each vector it computes one dense layer with optional ReLU, right-shift requantisation and saturation, then streams the result vector out. It generalises the fixed-size MLP IP to arbitrary layer dimensions and adds reload, framing-error and backpressure-safe output.

Parameters:
IN_SIZE, 3, input vector length (>=1)
OUT_SIZE, 6, output neurons (>=1)
DATA_WIDTH, 32, signed activation width in and out (<=32)
WEIGHT_WIDTH, 8, signed weight width, taken from TDATA[WEIGHT_WIDTH-1:0]
BIAS_WIDTH, 32, signed bias width, taken from TDATA[BIAS_WIDTH-1:0]
ACC_WIDTH, 48, signed accumulator width (>= DATA_WIDTH+WEIGHT_WIDTH+clog2(IN_SIZE)+1)
OUT_SHIFT, 0, arithmetic right shift applied before saturation
RELU_EN, 1, 1 = clamp negative neuron sums to 0

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous active-high reset
S_AXIS_TDATA  in  32  weight, bias or input word
S_AXIS_TVALID  in  1  input word valid
S_AXIS_TREADY  out  1  engine accepts input
S_AXIS_TLAST  in  1  frame end marker, checked only
S_AXIS_TKEEP  in  4  ignored
M_AXIS_TDATA  out  32  result, sign-extended from DATA_WIDTH
M_AXIS_TVALID  out  1  result valid
M_AXIS_TREADY  in  1  sink ready
M_AXIS_TLAST  out  1  high on the last result of a vector
M_AXIS_TKEEP  out  4  constant 4'hF
cfg_reload  in  1  one-cycle pulse: request a new weight/bias load
frame_err  out  1  sticky framing error
busy  out  1  high in COMPUTE or SEND

Behaviour:
- Reset (async, any state): state goes to LOAD, all counters 0, frame_err=0. All outputs 0 except M_AXIS_TKEEP=4'hF. Weight/bias memory contents become don't-care and must be reloaded.
- A transfer occurs on TVALID&&TREADY at a rising edge.
- S_AXIS_TREADY=1 only in LOAD and RECV. M_AXIS_TVALID=1 only in SEND.
- LOAD:
  - Accepts OUT_SIZE*IN_SIZE weights, neuron-major: w[o][i] at index o*IN_SIZE+i.
  - Then accepts OUT_SIZE biases b[o].
  - Words are sign-extended to ACC_WIDTH on use.
  - After the final word, go to RECV.
- RECV: accepts IN_SIZE words x[i], full DATA_WIDTH signed. After the IN_SIZE-th word, go to COMPUTE on the next cycle.
- COMPUTE:
  - One MAC per cycle; exactly OUT_SIZE*IN_SIZE cycles.
  - For each neuron o: acc = b[o] + sum over i of x[i]*w[o][i].
  - Post-processing on the cycle of the neuron's last MAC: ReLU (if RELU_EN), then arithmetic >> OUT_SHIFT, then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. The result is written to y[o].
  - After the last neuron, go to SEND.
- SEND:
  - Presents y[k] for k=0..OUT_SIZE-1; k advances on handshake.
  - TDATA and TLAST stay stable while TREADY=0.
  - TLAST=1 only for k=OUT_SIZE-1.
  - After the last handshake, go to RECV (or LOAD if a reload is pending) on the next cycle.
- Latency: the first output is valid IN_SIZE*OUT_SIZE+1 cycles after the last input handshake.
- TLAST checking: word counts alone decide frame boundaries. frame_err is set in either case below:
  - TLAST=1 on any accepted word other than the last of a load or input frame.
  - TLAST=0 on the last word of a frame.
  - Processing continues normally after the error.
- cfg_reload:
  - In RECV with 0 words received: go to LOAD next cycle and clear frame_err.
  - Otherwise: latch as pending and take it at the next entry to RECV. The partially received vector is discarded.
- An input stall (TVALID=0) mid-frame holds the counters. No timeout.
- busy=1 exactly in COMPUTE and SEND.

Test Plan:
- IN=3, OUT=2, RELU_EN=1, SHIFT=0. Load w=[1,2,3,-1,-1,-1], b=[10,5]; input [34,7,25] -> outputs 133 then 0 (raw sum -61), TLAST on the second; first TVALID exactly 7 cycles after the last input handshake.
- Same config with RELU_EN=0 -> outputs 133, 0xFFFFFFC3 (-61). With OUT_SHIFT=2 -> 33, -16.
- Saturation: w0=[127,127,127], b0=0, x=[2^31-1,2^31-1,2^31-1] -> 0x7FFFFFFF; negation with RELU_EN=0 -> 0x80000000.
- Backpressure: hold M_AXIS_TREADY=0 for 3 cycles on the first beat -> TDATA stays 133 and TLAST stays 0; S_AXIS_TREADY stays 0 throughout.
- Framing: TLAST on the 2nd input word -> frame_err=1 and the vector still completes. cfg_reload in idle RECV -> frame_err=0 and LOAD accepts a new set; outputs reflect the new weights.
- ARESET asserted mid-COMPUTE -> all outputs 0 the same cycle; after release, S_AXIS_TREADY=1 in LOAD and behaviour matches a clean start.

Source files
------------

// File: rtl/axis_fc_layer_engine.sv
// AXI-Stream fully-connected layer engine: loads weights/biases once, then for
// each input vector computes y = sat((relu(W*x + b)) >>> OUT_SHIFT) with one MAC
// per cycle and streams the result vector out with backpressure.
module axis_fc_layer_engine #(
    parameter int IN_SIZE      = 3,
    parameter int OUT_SIZE     = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 32,
    parameter int ACC_WIDTH    = 48,
    parameter int OUT_SHIFT    = 0,
    parameter int RELU_EN      = 1
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic        S_AXIS_TLAST,
    input  logic [3:0]  S_AXIS_TKEEP,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TLAST,
    output logic [3:0]  M_AXIS_TKEEP,
    input  logic        cfg_reload,
    output logic        frame_err,
    output logic        busy
);

    localparam int NumW    = OUT_SIZE * IN_SIZE;
    localparam int NumLoad = NumW + OUT_SIZE;
    localparam int LdW     = $clog2(NumLoad + 1);
    localparam int InW     = $clog2(IN_SIZE + 1);
    localparam int OutW    = $clog2(OUT_SIZE + 1);
    localparam int WAdrW   = (NumW > 1) ? $clog2(NumW) : 1;
    localparam int XAdrW   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int YAdrW   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [1:0] StLoad    = 2'd0;
    localparam logic [1:0] StRecv    = 2'd1;
    localparam logic [1:0] StCompute = 2'd2;
    localparam logic [1:0] StSend    = 2'd3;

    localparam logic signed [ACC_WIDTH-1:0] SatMax =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SatMin = ~SatMax;

    // Parameter storage and vectors; contents are don't-care after reset.
    logic signed [WEIGHT_WIDTH-1:0] w_mem [NumW];
    logic signed [BIAS_WIDTH-1:0]   b_mem [OUT_SIZE];
    logic signed [DATA_WIDTH-1:0]   x_mem [IN_SIZE];
    logic signed [DATA_WIDTH-1:0]   y_mem [OUT_SIZE];

    logic [1:0]                  state_q, state_d;
    logic [LdW-1:0]              load_cnt_q;
    logic [InW-1:0]              in_cnt_q;
    logic                        x_full_q;      // full vector held, one cycle before COMPUTE
    logic [InW-1:0]              mac_i_q;
    logic [OutW-1:0]             mac_o_q;
    logic [OutW-1:0]             out_k_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        frame_err_q, frame_err_d;
    logic                        reload_pend_q, reload_pend_d;
    logic                        reload_take;

    logic s_hs, m_hs;
    logic load_last, in_last, mac_last_i, mac_last_o, send_last, load_is_w, frame_word_last;

    logic [WAdrW-1:0]            w_idx;
    logic signed [DATA_WIDTH-1:0]   x_sel;
    logic signed [WEIGHT_WIDTH-1:0] w_sel;
    logic signed [BIAS_WIDTH-1:0]   b_sel;
    logic signed [DATA_WIDTH-1:0]   y_sel;
    logic signed [ACC_WIDTH-1:0] acc_base, acc_sum, relu_val, shifted, sat;
    logic                        unused_bits;

    assign s_hs       = S_AXIS_TVALID && S_AXIS_TREADY;
    assign m_hs       = M_AXIS_TVALID && M_AXIS_TREADY;
    assign load_last  = (load_cnt_q == LdW'(NumLoad - 1));
    assign load_is_w  = (load_cnt_q < LdW'(NumW));
    assign in_last    = (in_cnt_q == InW'(IN_SIZE - 1));
    assign mac_last_i = (mac_i_q == InW'(IN_SIZE - 1));
    assign mac_last_o = (mac_o_q == OutW'(OUT_SIZE - 1));
    assign send_last  = (out_k_q == OutW'(OUT_SIZE - 1));
    assign frame_word_last = (state_q == StLoad) ? load_last : in_last;

    // Ready is held low during reset so every output reads 0 while ARESET is high.
    assign S_AXIS_TREADY = !ARESET && ((state_q == StLoad) || (state_q == StRecv && !x_full_q));
    assign M_AXIS_TVALID = (state_q == StSend);
    assign y_sel         = y_mem[YAdrW'(out_k_q)];
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? 32'(y_sel) : 32'd0;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && send_last;
    assign M_AXIS_TKEEP  = 4'hF;
    assign busy          = (state_q == StCompute) || (state_q == StSend);
    assign frame_err     = frame_err_q;
    assign unused_bits   = ^{S_AXIS_TKEEP, S_AXIS_TDATA, sat};

    // MAC datapath with ReLU, arithmetic shift and saturation of the running sum.
    always_comb begin
        w_idx    = WAdrW'(int'(mac_o_q) * IN_SIZE + int'(mac_i_q));
        x_sel    = x_mem[XAdrW'(mac_i_q)];
        w_sel    = w_mem[w_idx];
        b_sel    = b_mem[YAdrW'(mac_o_q)];
        acc_base = (mac_i_q == '0) ? ACC_WIDTH'(b_sel) : acc_q;
        acc_sum  = acc_base + ACC_WIDTH'(x_sel) * ACC_WIDTH'(w_sel);
        relu_val = (RELU_EN != 0 && acc_sum[ACC_WIDTH-1]) ? '0 : acc_sum;
        shifted  = relu_val >>> OUT_SHIFT;
        if (shifted > SatMax) begin
            sat = SatMax;
        end else if (shifted < SatMin) begin
            sat = SatMin;
        end else begin
            sat = shifted;
        end
    end

    // Next-state, reload arbitration and sticky framing error.
    always_comb begin
        state_d     = state_q;
        reload_take = 1'b0;
        case (state_q)
            StLoad: begin
                if (s_hs && load_last) begin
                    if (reload_pend_q || cfg_reload) begin
                        reload_take = 1'b1;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                // A reload aborts any partially received vector.
                if (cfg_reload && !x_full_q) begin
                    state_d     = StLoad;
                    reload_take = 1'b1;
                end else if (x_full_q) begin
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (mac_last_i && mac_last_o) state_d = StSend;
            end
            StSend: begin
                if (m_hs && send_last) begin
                    if (reload_pend_q || cfg_reload) begin
                        state_d     = StLoad;
                        reload_take = 1'b1;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            default: state_d = StLoad;
        endcase

        reload_pend_d = reload_take ? 1'b0 : (reload_pend_q || cfg_reload);

        frame_err_d = frame_err_q;
        if (state_q == StRecv && cfg_reload && in_cnt_q == '0 && !x_full_q) begin
            frame_err_d = 1'b0;
        end else if (s_hs && !(state_q == StRecv && cfg_reload)
                     && (S_AXIS_TLAST != frame_word_last)) begin
            frame_err_d = 1'b1;
        end
    end

    // Control state and counters.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= StLoad;
            load_cnt_q    <= '0;
            in_cnt_q      <= '0;
            x_full_q      <= 1'b0;
            mac_i_q       <= '0;
            mac_o_q       <= '0;
            out_k_q       <= '0;
            acc_q         <= '0;
            frame_err_q   <= 1'b0;
            reload_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_err_q   <= frame_err_d;
            reload_pend_q <= reload_pend_d;
            case (state_q)
                StLoad: begin
                    if (s_hs) load_cnt_q <= load_last ? '0 : load_cnt_q + LdW'(1);
                end
                StRecv: begin
                    if (cfg_reload && !x_full_q) begin
                        in_cnt_q <= '0;
                    end else if (x_full_q) begin
                        x_full_q <= 1'b0;
                    end else if (s_hs) begin
                        if (in_last) begin
                            in_cnt_q <= '0;
                            x_full_q <= 1'b1;
                        end else begin
                            in_cnt_q <= in_cnt_q + InW'(1);
                        end
                    end
                end
                StCompute: begin
                    acc_q <= acc_sum;
                    if (mac_last_i) begin
                        mac_i_q <= '0;
                        mac_o_q <= mac_last_o ? '0 : mac_o_q + OutW'(1);
                    end else begin
                        mac_i_q <= mac_i_q + InW'(1);
                    end
                end
                StSend: begin
                    if (m_hs) out_k_q <= send_last ? '0 : out_k_q + OutW'(1);
                end
                default: ;
            endcase
        end
    end

    // Storage writes: parameters in LOAD, inputs in RECV, results on each neuron's last MAC.
    always_ff @(posedge ACLK) begin
        if (state_q == StLoad && s_hs) begin
            if (load_is_w) begin
                w_mem[WAdrW'(load_cnt_q)] <= S_AXIS_TDATA[WEIGHT_WIDTH-1:0];
            end else begin
                b_mem[YAdrW'(load_cnt_q - LdW'(NumW))] <= S_AXIS_TDATA[BIAS_WIDTH-1:0];
            end
        end
        if (state_q == StRecv && s_hs && !x_full_q) begin
            x_mem[XAdrW'(in_cnt_q)] <= S_AXIS_TDATA[DATA_WIDTH-1:0];
        end
        if (state_q == StCompute && mac_last_i) begin
            y_mem[YAdrW'(mac_o_q)] <= sat[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_axis_fc_layer_engine.sv
// Directed bench: three engines (ReLU/no-shift, no-ReLU/no-shift, no-ReLU/shift 2)
// share one input stream so each vector checks all post-processing variants.
module tb_axis_fc_layer_engine;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, m_tready, cfg_reload;
    logic [3:0]  s_tkeep;

    logic [31:0] a_tdata, b_tdata, c_tdata;
    logic        a_tvalid, b_tvalid, c_tvalid;
    logic        a_tlast, b_tlast, c_tlast;
    logic        a_sready, b_sready, c_sready;
    logic [3:0]  a_keep, b_keep, c_keep;
    logic        a_ferr, b_ferr, c_ferr;
    logic        a_busy, b_busy, c_busy;

    int errors = 0;
    int checks = 0;
    int lat;

    logic [31:0] wa [8] = '{32'd1, 32'd2, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'd10, 32'd5};
    logic [31:0] ws [8] = '{32'h7F, 32'h7F, 32'h7F, 32'hFFFFFF81, 32'hFFFFFF81, 32'hFFFFFF81,
                            32'd0, 32'd0};

    always #5 ACLK = ~ACLK;

    axis_fc_layer_engine #(.IN_SIZE(3), .OUT_SIZE(2), .RELU_EN(1), .OUT_SHIFT(0)) dut_a (
        .ACLK(ACLK), .ARESET(ARESET), .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TREADY(a_sready), .S_AXIS_TLAST(s_tlast), .S_AXIS_TKEEP(s_tkeep),
        .M_AXIS_TDATA(a_tdata), .M_AXIS_TVALID(a_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TLAST(a_tlast), .M_AXIS_TKEEP(a_keep), .cfg_reload(cfg_reload),
        .frame_err(a_ferr), .busy(a_busy));

    axis_fc_layer_engine #(.IN_SIZE(3), .OUT_SIZE(2), .RELU_EN(0), .OUT_SHIFT(0)) dut_b (
        .ACLK(ACLK), .ARESET(ARESET), .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TREADY(b_sready), .S_AXIS_TLAST(s_tlast), .S_AXIS_TKEEP(s_tkeep),
        .M_AXIS_TDATA(b_tdata), .M_AXIS_TVALID(b_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TLAST(b_tlast), .M_AXIS_TKEEP(b_keep), .cfg_reload(cfg_reload),
        .frame_err(b_ferr), .busy(b_busy));

    axis_fc_layer_engine #(.IN_SIZE(3), .OUT_SIZE(2), .RELU_EN(0), .OUT_SHIFT(2)) dut_c (
        .ACLK(ACLK), .ARESET(ARESET), .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TREADY(c_sready), .S_AXIS_TLAST(s_tlast), .S_AXIS_TKEEP(s_tkeep),
        .M_AXIS_TDATA(c_tdata), .M_AXIS_TVALID(c_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TLAST(c_tlast), .M_AXIS_TKEEP(c_keep), .cfg_reload(cfg_reload),
        .frame_err(c_ferr), .busy(c_busy));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One input word; waits (bounded) for ready, handshake happens on the next edge.
    task automatic put(input logic [31:0] d, input logic l);
        int n = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        while (!a_sready && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        check("s_ready", {31'd0, a_sready}, 32'd1);
        @(posedge ACLK); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic load_words(input logic [31:0] words [8]);
        for (int i = 0; i < 8; i++) put(words[i], i == 7);
    endtask

    // Accept one output beat and compare all three engines.
    task automatic get_beat(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ec, input logic el);
        int n = 0;
        m_tready = 1'b1;
        while (!a_tvalid && n < 50) begin
            @(posedge ACLK); #1;
            n++;
        end
        check({tag, "_valid"}, {31'd0, a_tvalid}, 32'd1);
        check({tag, "_a"}, a_tdata, ea);
        check({tag, "_b"}, b_tdata, eb);
        check({tag, "_c"}, c_tdata, ec);
        check({tag, "_last"}, {31'd0, a_tlast}, {31'd0, el});
        @(posedge ACLK); #1;
    endtask

    initial begin
        ARESET     = 1'b1;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tkeep    = 4'hF;
        m_tready   = 1'b0;
        cfg_reload = 1'b0;
        #12;
        check("rst_valid", {31'd0, a_tvalid}, 32'd0);
        check("rst_data", a_tdata, 32'd0);
        check("rst_last", {31'd0, a_tlast}, 32'd0);
        check("rst_keep", {28'd0, a_keep}, 32'hF);
        check("rst_sready", {31'd0, a_sready}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_ferr", {31'd0, a_ferr}, 32'd0);
        #10 ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("load_sready", {31'd0, a_sready}, 32'd1);

        // Basic vector with latency and backpressure on the first beat.
        load_words(wa);
        check("recv_ferr", {31'd0, a_ferr}, 32'd0);
        put(32'd34, 1'b0);
        put(32'd7, 1'b0);
        put(32'd25, 1'b1);
        lat = 0;
        while (!a_tvalid && lat < 50) begin
            @(posedge ACLK); #1;
            lat++;
        end
        check("latency", lat, 32'd7);
        for (int i = 0; i < 3; i++) begin
            check("bp_data", a_tdata, 32'd133);
            check("bp_last", {31'd0, a_tlast}, 32'd0);
            check("bp_sready", {31'd0, a_sready}, 32'd0);
            check("bp_busy", {31'd0, a_busy}, 32'd1);
            @(posedge ACLK); #1;
        end
        get_beat("v0b0", 32'd133, 32'd133, 32'd33, 1'b0);
        get_beat("v0b1", 32'd0, 32'hFFFFFFC3, 32'hFFFFFFF0, 1'b1);
        check("post_valid", {31'd0, a_tvalid}, 32'd0);
        check("post_sready", {31'd0, a_sready}, 32'd1);
        check("post_busy", {31'd0, a_busy}, 32'd0);

        // Early TLAST on the second word: error flagged, vector still completes.
        put(32'd34, 1'b0);
        put(32'd7, 1'b1);
        put(32'd25, 1'b1);
        check("early_last_ferr", {31'd0, a_ferr}, 32'd1);
        get_beat("v1b0", 32'd133, 32'd133, 32'd33, 1'b0);
        get_beat("v1b1", 32'd0, 32'hFFFFFFC3, 32'hFFFFFFF0, 1'b1);
        check("ferr_sticky", {31'd0, a_ferr}, 32'd1);

        // Reload from idle RECV clears the error and takes a saturating weight set.
        cfg_reload = 1'b1;
        @(posedge ACLK); #1;
        cfg_reload = 1'b0;
        check("reload_ferr", {31'd0, a_ferr}, 32'd0);
        load_words(ws);
        put(32'h7FFFFFFF, 1'b0);
        put(32'h7FFFFFFF, 1'b0);
        put(32'h7FFFFFFF, 1'b1);
        get_beat("sat0", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        get_beat("sat1", 32'd0, 32'h80000000, 32'h80000000, 1'b1);

        // Missing TLAST on the last word, then reset in the middle of COMPUTE.
        put(32'd1, 1'b0);
        put(32'd2, 1'b0);
        put(32'd3, 1'b0);
        repeat (3) begin
            @(posedge ACLK); #1;
        end
        check("mid_busy", {31'd0, a_busy}, 32'd1);
        check("missing_last_ferr", {31'd0, a_ferr}, 32'd1);
        #2 ARESET = 1'b1;
        #1;
        check("arst_valid", {31'd0, a_tvalid}, 32'd0);
        check("arst_data", a_tdata, 32'd0);
        check("arst_busy", {31'd0, a_busy}, 32'd0);
        check("arst_sready", {31'd0, a_sready}, 32'd0);
        check("arst_ferr", {31'd0, a_ferr}, 32'd0);
        check("arst_keep", {28'd0, a_keep}, 32'hF);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check("rel_sready", {31'd0, a_sready}, 32'd1);
        check("rel_busy", {31'd0, a_busy}, 32'd0);

        // Clean start after reset behaves like the first run.
        load_words(wa);
        put(32'd34, 1'b0);
        put(32'd7, 1'b0);
        put(32'd25, 1'b1);
        lat = 0;
        while (!a_tvalid && lat < 50) begin
            @(posedge ACLK); #1;
            lat++;
        end
        check("latency2", lat, 32'd7);
        get_beat("v2b0", 32'd133, 32'd133, 32'd33, 1'b0);
        get_beat("v2b1", 32'd0, 32'hFFFFFFC3, 32'hFFFFFFF0, 1'b1);
        check("final_ferr", {31'd0, a_ferr}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
